// File: rtl/csb_to_periph_pkg.sv
// Shared types and constants for the CSB-to-periph bridge.
// Optional watchdog build macro: CSB_TO_PERIPH_TIMEOUT_EN.
package csb_to_periph_pkg;

  localparam int unsigned CSB_ADDR_W = 16;

  // Read data returned when a transaction is aborted by the watchdog.
  localparam logic [31:0] CSB_TO_PERIPH_ERR_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;

  // CSB word address to periph byte address; wraps modulo 2^32.
  function automatic logic [31:0] csb_byte_addr(input logic [31:0]           base,
                                                input logic [CSB_ADDR_W-1:0] addr);
    return base + {{(32 - CSB_ADDR_W - 2){1'b0}}, addr, 2'b00};
  endfunction

endpackage

// File: rtl/csb_to_periph_watchdog.sv
// Load/count/expire counter that bounds how long the bridge waits on the
// periph side. Only instantiated when CSB_TO_PERIPH_TIMEOUT_EN is defined.
module csb_to_periph_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic count_i,
  output logic expired_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Expire on the TIMEOUT_CYCLES-th counted cycle since the last load.
  assign expired_o = count_i && (cnt_q == LIMIT);

  // Next count: load clears, counting saturates at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (count_i && !expired_o) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/csb_to_periph.sv
// CSB responder that replays each CSB access as one HWPE periph master
// transaction. One transaction outstanding; CSB responses are registered.
// Optional build macro: CSB_TO_PERIPH_TIMEOUT_EN adds a watchdog that aborts
// a transaction after TIMEOUT_CYCLES cycles in REQ or RESP.
module csb_to_periph
  import csb_to_periph_pkg::*;
#(
  parameter int unsigned ID_WIDTH       = 1,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  // CSB responder side
  input  logic                  csb_valid_i,
  output logic                  csb_ready_o,
  input  logic [CSB_ADDR_W-1:0] csb_addr_i,
  input  logic [31:0]           csb_wdat_i,
  input  logic                  csb_write_i,
  input  logic                  csb_nposted_i,
  output logic                  csb_r_valid_o,
  output logic [31:0]           csb_r_data_o,
  output logic                  csb_wr_complete_o,
  // Periph master side
  output logic                  periph_req_o,
  output logic [31:0]           periph_add_o,
  output logic                  periph_wen_o,
  output logic [3:0]            periph_be_o,
  output logic [31:0]           periph_data_o,
  output logic [ID_WIDTH-1:0]   periph_id_o,
  input  logic                  periph_gnt_i,
  input  logic                  periph_r_valid_i,
  input  logic [31:0]           periph_r_data_i,
  input  logic [ID_WIDTH-1:0]   periph_r_id_i
);

  state_e      state_q, state_d;
  logic [31:0] add_q, add_d;
  logic [31:0] wdat_q, wdat_d;
  logic        wen_q, wen_d;
  logic        nposted_q, nposted_d;
  logic        r_valid_q, r_valid_d;
  logic [31:0] r_data_q, r_data_d;
  logic        wr_complete_q, wr_complete_d;
  logic        timeout;

  // The response id carries no information for a single-outstanding bridge,
  // and the timeout limit only matters in the watchdog build.
  logic unused_inputs;
  assign unused_inputs = ^{periph_r_id_i, TIMEOUT_CYCLES[0]};

`ifdef CSB_TO_PERIPH_TIMEOUT_EN
  logic wd_load;
  logic wd_count;

  // Cleared while idle and on the REQ->RESP step, so both phases get a
  // fresh budget; counts whenever a transaction is in flight.
  assign wd_load  = (state_q == IDLE) || ((state_q == REQ) && periph_gnt_i);
  assign wd_count = (state_q != IDLE);

  csb_to_periph_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .load_i   (wd_load),
    .count_i  (wd_count),
    .expired_o(timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  // Held low during reset even though the state register already reads IDLE.
  assign csb_ready_o       = (state_q == IDLE) && !rst;
  assign csb_r_valid_o     = r_valid_q;
  assign csb_r_data_o      = r_data_q;
  assign csb_wr_complete_o = wr_complete_q;

  assign periph_req_o  = (state_q == REQ);
  assign periph_add_o  = add_q;
  assign periph_wen_o  = wen_q;
  assign periph_data_o = wdat_q;
  assign periph_be_o   = 4'hF;
  assign periph_id_o   = '0;

  // Next-state, field capture and response generation.
  // NOTE: every variable gets a default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d       = state_q;
    add_d         = add_q;
    wdat_d        = wdat_q;
    wen_d         = wen_q;
    nposted_d     = nposted_q;
    r_data_d      = r_data_q;
    r_valid_d     = 1'b0;
    wr_complete_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (csb_valid_i) begin
          state_d   = REQ;
          add_d     = csb_byte_addr(BASE_ADDR, csb_addr_i);
          wdat_d    = csb_wdat_i;
          wen_d     = !csb_write_i;
          nposted_d = csb_nposted_i;
        end
      end

      REQ: begin
        if (periph_gnt_i) begin
          state_d = RESP;
        end else if (timeout) begin
          state_d       = IDLE;
          r_valid_d     = wen_q;
          wr_complete_d = !wen_q && nposted_q;
          if (wen_q) r_data_d = CSB_TO_PERIPH_ERR_DATA;
        end
      end

      RESP: begin
        if (periph_r_valid_i) begin
          state_d       = IDLE;
          r_valid_d     = wen_q;
          wr_complete_d = !wen_q && nposted_q;
          if (wen_q) r_data_d = periph_r_data_i;
        end else if (timeout) begin
          state_d       = IDLE;
          r_valid_d     = wen_q;
          wr_complete_d = !wen_q && nposted_q;
          if (wen_q) r_data_d = CSB_TO_PERIPH_ERR_DATA;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State, latched request fields and registered CSB response.
  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      add_q         <= '0;
      wdat_q        <= '0;
      wen_q         <= 1'b1;
      nposted_q     <= 1'b0;
      r_valid_q     <= 1'b0;
      r_data_q      <= '0;
      wr_complete_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      add_q         <= add_d;
      wdat_q        <= wdat_d;
      wen_q         <= wen_d;
      nposted_q     <= nposted_d;
      r_valid_q     <= r_valid_d;
      r_data_q      <= r_data_d;
      wr_complete_q <= wr_complete_d;
    end
  end

endmodule

// File: tb/tb_csb_to_periph.sv
// Directed bench for csb_to_periph with a response scoreboard.
// The watchdog scenario runs only when CSB_TO_PERIPH_TIMEOUT_EN is defined.
module tb_csb_to_periph;

  localparam logic [31:0] BASE = 32'h1A10_0000;

  typedef struct {
    logic        is_read;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        csb_valid_i = 1'b0;
  logic        csb_ready_o;
  logic [15:0] csb_addr_i = '0;
  logic [31:0] csb_wdat_i = '0;
  logic        csb_write_i = 1'b0;
  logic        csb_nposted_i = 1'b0;
  logic        csb_r_valid_o;
  logic [31:0] csb_r_data_o;
  logic        csb_wr_complete_o;
  logic        periph_req_o;
  logic [31:0] periph_add_o;
  logic        periph_wen_o;
  logic [3:0]  periph_be_o;
  logic [31:0] periph_data_o;
  logic [0:0]  periph_id_o;
  logic        periph_gnt_i = 1'b0;
  logic        periph_r_valid_i = 1'b0;
  logic [31:0] periph_r_data_i = '0;
  logic [0:0]  periph_r_id_i = '0;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  csb_to_periph #(
    .ID_WIDTH      (1),
    .BASE_ADDR     (BASE),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .csb_valid_i      (csb_valid_i),
    .csb_ready_o      (csb_ready_o),
    .csb_addr_i       (csb_addr_i),
    .csb_wdat_i       (csb_wdat_i),
    .csb_write_i      (csb_write_i),
    .csb_nposted_i    (csb_nposted_i),
    .csb_r_valid_o    (csb_r_valid_o),
    .csb_r_data_o     (csb_r_data_o),
    .csb_wr_complete_o(csb_wr_complete_o),
    .periph_req_o     (periph_req_o),
    .periph_add_o     (periph_add_o),
    .periph_wen_o     (periph_wen_o),
    .periph_be_o      (periph_be_o),
    .periph_data_o    (periph_data_o),
    .periph_id_o      (periph_id_o),
    .periph_gnt_i     (periph_gnt_i),
    .periph_r_valid_i (periph_r_valid_i),
    .periph_r_data_i  (periph_r_data_i),
    .periph_r_id_i    (periph_r_id_i)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a CSB request and wait (bounded) for the handshake; on return we
  // are one cycle past the accept edge. The expected response is queued.
  task automatic csb_send(input logic [15:0] addr, input logic [31:0] wdat,
                          input logic write, input logic nposted,
                          input logic [31:0] rdata);
    logic ok;
    ok            = 1'b0;
    csb_valid_i   = 1'b1;
    csb_addr_i    = addr;
    csb_wdat_i    = wdat;
    csb_write_i   = write;
    csb_nposted_i = nposted;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (csb_ready_o) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check("csb_accept", ok, 1'b1);
    if (!write) sb.push_back('{is_read: 1'b1, data: rdata});
    else if (nposted) sb.push_back('{is_read: 1'b0, data: 32'h0});
    tick();
    csb_valid_i = 1'b0;
  endtask

  // Scoreboard: every CSB response pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && (csb_r_valid_o || csb_wr_complete_o)) begin
      check("resp_single_kind", csb_r_valid_o & csb_wr_complete_o, 1'b0);
      check("resp_expected", sb.size() != 0, 1'b1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check("resp_kind", csb_r_valid_o, e.is_read);
        if (e.is_read) check("resp_data", csb_r_data_o, e.data);
      end
    end
  end

  initial begin
    // ---------------- reset state ----------------
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", csb_ready_o, 1'b0);
    check("rst_req", periph_req_o, 1'b0);
    check("rst_rvalid", csb_r_valid_o, 1'b0);
    check("rst_wrc", csb_wr_complete_o, 1'b0);
    check("rst_rdata", csb_r_data_o, 32'h0);
    check("rst_add", periph_add_o, 32'h0);
    check("rst_pdata", periph_data_o, 32'h0);
    check("rst_wen", periph_wen_o, 1'b1);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("idle_ready", csb_ready_o, 1'b1);
    tick();

    // ---------------- read, immediate grant ----------------
    csb_send(16'h0010, 32'h0, 1'b0, 1'b0, 32'hCAFE_0001);
    periph_gnt_i = 1'b1;
    @(negedge clk);
    check("rd_req", periph_req_o, 1'b1);
    check("rd_add", periph_add_o, 32'h1A10_0040);
    check("rd_wen", periph_wen_o, 1'b1);
    check("rd_be", periph_be_o, 4'hF);
    check("rd_id", periph_id_o, 1'b0);
    check("rd_ready_busy", csb_ready_o, 1'b0);
    tick();
    periph_gnt_i     = 1'b0;
    periph_r_valid_i = 1'b1;
    periph_r_data_i  = 32'hCAFE_0001;
    @(negedge clk);
    check("rd_req_resp", periph_req_o, 1'b0);
    check("rd_no_early", csb_r_valid_o, 1'b0);
    tick();
    periph_r_valid_i = 1'b0;
    periph_r_data_i  = 32'h0;
    @(negedge clk);
    check("rd_pulse", csb_r_valid_o, 1'b1);
    check("rd_data", csb_r_data_o, 32'hCAFE_0001);
    check("rd_ready_back", csb_ready_o, 1'b1);
    tick();
    @(negedge clk);
    check("rd_pulse_end", csb_r_valid_o, 1'b0);
    check("rd_data_hold", csb_r_data_o, 32'hCAFE_0001);
    tick();

    // ---------------- non-posted write, grant withheld 4 cycles ----------------
    csb_send(16'h0003, 32'h1234_5678, 1'b1, 1'b1, 32'h0);
    for (int i = 0; i < 5; i++) begin
      periph_gnt_i = (i == 4);
      @(negedge clk);
      check("npw_req", periph_req_o, 1'b1);
      check("npw_add", periph_add_o, 32'h1A10_000C);
      check("npw_data", periph_data_o, 32'h1234_5678);
      check("npw_wen", periph_wen_o, 1'b0);
      check("npw_be", periph_be_o, 4'hF);
      tick();
    end
    periph_gnt_i = 1'b0;
    @(negedge clk);
    check("npw_req_drop", periph_req_o, 1'b0);
    tick();
    periph_r_valid_i = 1'b1;
    @(negedge clk);
    check("npw_no_early", csb_wr_complete_o, 1'b0);
    tick();
    periph_r_valid_i = 1'b0;
    @(negedge clk);
    check("npw_complete", csb_wr_complete_o, 1'b1);
    check("npw_no_rvalid", csb_r_valid_o, 1'b0);
    tick();
    @(negedge clk);
    check("npw_complete_end", csb_wr_complete_o, 1'b0);
    tick();

    // ---------------- posted write, next request waits ----------------
    csb_send(16'h0005, 32'hA5A5_0005, 1'b1, 1'b0, 32'h0);
    periph_gnt_i = 1'b1;
    @(negedge clk);
    check("pw_wen", periph_wen_o, 1'b0);
    tick();
    periph_gnt_i  = 1'b0;
    csb_valid_i   = 1'b1;
    csb_addr_i    = 16'h0006;
    csb_write_i   = 1'b0;
    csb_nposted_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      periph_r_valid_i = (i == 2);
      @(negedge clk);
      check("pw_ready_low", csb_ready_o, 1'b0);
      tick();
    end
    periph_r_valid_i = 1'b0;
    @(negedge clk);
    check("pw_ready_next", csb_ready_o, 1'b1);
    check("pw_no_wrc", csb_wr_complete_o, 1'b0);
    check("pw_no_rvalid", csb_r_valid_o, 1'b0);
    sb.push_back('{is_read: 1'b1, data: 32'h0BAD_0006});
    tick();
    csb_valid_i  = 1'b0;
    periph_gnt_i = 1'b1;
    @(negedge clk);
    check("pw_next_req", periph_req_o, 1'b1);
    check("pw_next_add", periph_add_o, 32'h1A10_0018);
    tick();
    periph_gnt_i     = 1'b0;
    periph_r_valid_i = 1'b1;
    periph_r_data_i  = 32'h0BAD_0006;
    tick();
    periph_r_valid_i = 1'b0;
    @(negedge clk);
    check("pw_next_pulse", csb_r_valid_o, 1'b1);
    tick();

    // ---------------- back-to-back reads, valid held high ----------------
    csb_valid_i = 1'b1;
    csb_addr_i  = 16'h0020;
    csb_write_i = 1'b0;
    @(negedge clk);
    check("b2b_first_ready", csb_ready_o, 1'b1);
    sb.push_back('{is_read: 1'b1, data: 32'h1111_0001});
    tick();
    csb_addr_i   = 16'h0021;
    periph_gnt_i = 1'b1;
    @(negedge clk);
    check("b2b_add0", periph_add_o, 32'h1A10_0080);
    tick();
    periph_gnt_i     = 1'b0;
    periph_r_valid_i = 1'b1;
    periph_r_data_i  = 32'h1111_0001;
    tick();
    periph_r_valid_i = 1'b0;
    @(negedge clk);
    check("b2b_pulse0", csb_r_valid_o, 1'b1);
    check("b2b_accept1", csb_ready_o, 1'b1);
    sb.push_back('{is_read: 1'b1, data: 32'h2222_0002});
    tick();
    csb_valid_i  = 1'b0;
    periph_gnt_i = 1'b1;
    @(negedge clk);
    check("b2b_req1", periph_req_o, 1'b1);
    check("b2b_add1", periph_add_o, 32'h1A10_0084);
    tick();
    periph_gnt_i     = 1'b0;
    periph_r_valid_i = 1'b1;
    periph_r_data_i  = 32'h2222_0002;
    tick();
    periph_r_valid_i = 1'b0;
    @(negedge clk);
    check("b2b_pulse1", csb_r_valid_o, 1'b1);
    tick();

    // ---------------- reset during RESP ----------------
    csb_send(16'h0030, 32'h0, 1'b0, 1'b0, 32'h7777_7777);
    periph_gnt_i = 1'b1;
    tick();
    periph_gnt_i = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    sb.delete();
    check("arst_ready", csb_ready_o, 1'b0);
    check("arst_req", periph_req_o, 1'b0);
    check("arst_rvalid", csb_r_valid_o, 1'b0);
    check("arst_wrc", csb_wr_complete_o, 1'b0);
    check("arst_rdata", csb_r_data_o, 32'h0);
    check("arst_add", periph_add_o, 32'h0);
    check("arst_pdata", periph_data_o, 32'h0);
    check("arst_wen", periph_wen_o, 1'b1);
    tick();
    rst = 1'b0;
    periph_r_valid_i = 1'b1;
    periph_r_data_i  = 32'h7777_7777;
    @(negedge clk);
    check("stray_ready", csb_ready_o, 1'b1);
    check("stray_req", periph_req_o, 1'b0);
    tick();
    periph_r_valid_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("stray_no_rvalid", csb_r_valid_o, 1'b0);
      check("stray_no_wrc", csb_wr_complete_o, 1'b0);
      tick();
    end

`ifdef CSB_TO_PERIPH_TIMEOUT_EN
    // ---------------- watchdog abort of an ungranted read ----------------
    begin
      logic seen;
      seen = 1'b0;
      csb_send(16'h0040, 32'h0, 1'b0, 1'b0, 32'hDEAD_BEEF);
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (csb_r_valid_o) begin
          seen = 1'b1;
          break;
        end
        tick();
      end
      check("wd_abort_seen", seen, 1'b1);
      check("wd_abort_data", csb_r_data_o, 32'hDEAD_BEEF);
      check("wd_req_drop", periph_req_o, 1'b0);
      check("wd_ready", csb_ready_o, 1'b1);
      tick();
      periph_r_valid_i = 1'b1;
      periph_r_data_i  = 32'h5555_5555;
      tick();
      periph_r_valid_i = 1'b0;
      @(negedge clk);
      check("wd_late_ignored", csb_r_valid_o, 1'b0);
      tick();
    end
`endif

    repeat (3) tick();
    check("sb_drained", sb.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: observed no completion expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/csb_to_periph.md
# csb_to_periph

Bridge that terminates an NVDLA CSB request stream as a CSB responder and replays each access as a single HWPE peripheral master transaction. It sits where a CSB initiator (NVDLA-side config master or test harness) must reach HWPE-style register targets. It is the reverse of the existing periph-to-CSB path. At most one transaction is outstanding; CSB responses are registered.

## Interface
- `ID_WIDTH`, default 1: width of periph id fields.
- `BASE_ADDR`, default 32'h0000_0000: periph byte address corresponding to CSB word address 0.
- `TIMEOUT_CYCLES`, default 256: watchdog limit in cycles; used only with `CSB_TO_PERIPH_TIMEOUT_EN`.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `csb_valid_i` in 1: CSB request valid.
- `csb_ready_o` out 1: CSB request accepted when valid&ready.
- `csb_addr_i` in 16: CSB word address.
- `csb_wdat_i` in 32: write data.
- `csb_write_i` in 1: 1 means write, 0 means read.
- `csb_nposted_i` in 1: write requires `wr_complete`.
- `csb_r_valid_o` out 1: one-cycle read-data pulse.
- `csb_r_data_o` out 32: read data, valid with `csb_r_valid_o`.
- `csb_wr_complete_o` out 1: one-cycle non-posted write completion.
- `periph_req_o` out 1: periph request.
- `periph_add_o` out 32: byte address, `BASE_ADDR + {csb_addr,2'b00}`, modulo 2^32.
- `periph_wen_o` out 1: 0 means write, 1 means read.
- `periph_be_o` out 4: always 4'hF.
- `periph_data_o` out 32: write data.
- `periph_id_o` out ID_WIDTH: always 0.
- `periph_gnt_i` in 1: request grant.
- `periph_r_valid_i` in 1: response valid, for reads and writes.
- `periph_r_data_i` in 32: read data.
- `periph_r_id_i` in ID_WIDTH: response id, ignored.

## Operation
- FSM states are IDLE, REQ and RESP.
- IDLE:
  - `csb_ready_o`=1.
  - On `csb_valid_i`, latch addr, wdat, write and nposted, then go to REQ.
- REQ:
  - `periph_req_o`=1, driven from the latched fields; fields are stable until grant.
  - On `periph_gnt_i`, go to RESP.
- RESP:
  - `periph_req_o`=0; wait for `periph_r_valid_i`.
  - On `periph_r_valid_i`, go to IDLE and register the response for the next cycle:
    - read: `csb_r_valid_o`=1, `csb_r_data_o`=`periph_r_data_i`.
    - non-posted write: `csb_wr_complete_o`=1.
    - posted write: no CSB response; the periph response is still consumed.
- `periph_r_valid_i` outside RESP is ignored.
- `csb_r_data_o` holds its last value when `csb_r_valid_o`=0.
- Reset clears the FSM to IDLE and discards any in-flight transaction; no response is produced for it.
- Reset values: `csb_ready_o`=0 while `rst` is high, then 1 in IDLE; `csb_r_valid_o`, `csb_wr_complete_o`, `periph_req_o`=0; `csb_r_data_o`, `periph_add_o`, `periph_data_o`=0; `periph_wen_o`=1.

## Timing
- Cycle 0: CSB handshake accepted.
- Cycle 1: `periph_req_o` high. A grant in cycle 1 means 1 cycle in REQ.
- Cycle ≥2: `periph_r_valid_i` arrives in cycle N.
- Cycle N+1: `csb_r_valid_o` / `csb_wr_complete_o` pulse, concurrently with `csb_ready_o`=1.
- Minimum CSB-accept to CSB-response: 3 cycles. Back-to-back accepts: every N+1 cycles.
- A new request accepted in cycle N+1 overlaps the response pulse of the previous transaction; this is legal.

## Configuration
- Macro `CSB_TO_PERIPH_TIMEOUT_EN`, defined: watchdog counter.
  - Cleared on entry to REQ and to RESP; counts while in REQ or RESP.
  - On reaching `TIMEOUT_CYCLES`: drop `periph_req_o` and return to IDLE.
  - Abort response: reads return `csb_r_data_o`=32'hDEAD_BEEF with `csb_r_valid_o`; non-posted writes pulse `csb_wr_complete_o`.
  - A late `periph_r_valid_i` after an abort is ignored in IDLE.
- Macro undefined: no counter; the bridge waits indefinitely.

## Structure
- Package `csb_to_periph_pkg`: state enum (IDLE/REQ/RESP), `CSB_TO_PERIPH_ERR_DATA`=32'hDEAD_BEEF, `CSB_ADDR_W`=16.
- Sub-module `csb_to_periph_watchdog`: load/count/expire counter; instantiated only under the macro.

## Test plan
- Read addr 16'h0010 with `BASE_ADDR`=32'h1A10_0000, gnt immediate, r_valid one cycle later with data 32'hCAFE_0001:
  - `periph_add_o`=32'h1A10_0040, `periph_wen_o`=1.
  - `csb_r_valid_o` pulses once with 32'hCAFE_0001, 3 cycles after accept.
- Non-posted write addr 16'h0003, data 32'h1234_5678, gnt withheld 4 cycles:
  - `periph_req_o` high 5 cycles with address and data stable, `periph_wen_o`=0, `be`=4'hF.
  - `csb_wr_complete_o` pulses once, the cycle after r_valid.
- Posted write:
  - no `csb_wr_complete_o` and no `csb_r_valid_o`.
  - `csb_ready_o` stays low until r_valid; the next request is accepted the cycle after r_valid.
- Back-to-back reads with `csb_valid_i` held high: the second accept coincides with the first `csb_r_valid_o` pulse; data returns in order.
- Assert `rst` during RESP:
  - all outputs return to reset values immediately.
  - a subsequent stray `periph_r_valid_i` produces no CSB response.
- With `CSB_TO_PERIPH_TIMEOUT_EN` and `TIMEOUT_CYCLES`=8, a read that never gets gnt: abort with `csb_r_valid_o` and 32'hDEAD_BEEF, then IDLE.
